// File: rtl/m_wb_controller.sv
// Main-memory-side controller: fill reads and write-backs from the cache, with a
// coalescing write-back FIFO drained to RAM in idle cycles and forwarding to reads.
module m_wb_controller #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         req_valid,
    input  logic                         req_wren,
    input  logic [AW-1:0]                req_address,
    input  logic [DW-1:0]                req_data,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [DW-1:0]                resp_data,
    output logic [AW-1:0]                mp_address,
    output logic [DW-1:0]                mp_data,
    output logic                         mp_wren,
    input  logic [DW-1:0]                mp_out,
    output logic [$clog2(DEPTH+1)-1:0]   wb_count,
    output logic                         busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   buf_addr_q [DEPTH];
    logic [AW-1:0]   buf_addr_d [DEPTH];
    logic [DW-1:0]   buf_data_q [DEPTH];
    logic [DW-1:0]   buf_data_d [DEPTH];
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic [AW-1:0]   mp_address_q, mp_address_d;
    logic [DW-1:0]   mp_data_q, mp_data_d;
    logic            mp_wren_q, mp_wren_d;
    logic            hit;
    logic [PW-1:0]   hit_idx;
    logic [PW-1:0]   offset;
    logic            accept;

    // Occupancy of slot i comes from its distance to head; coalescing keeps matches unique.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head_q;
            if ((CW'(offset) < count_q) && (buf_addr_q[i] == req_address)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign req_ready = (state_q == IDLE) && (count_q != CW'(DEPTH));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mp_address_d = mp_address_q;
        mp_data_d    = mp_data_q;
        mp_wren_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_wren) begin
                        if (hit) begin
                            buf_data_d[hit_idx] = req_data;
                        end else begin
                            buf_addr_d[tail_q] = req_address;
                            buf_data_d[tail_q] = req_data;
                            tail_d             = tail_q + 1'b1;
                            count_d            = count_q + 1'b1;
                        end
                    end else if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = buf_data_q[hit_idx];
                    end else begin
                        mp_address_d = req_address;
                        state_d      = RD_ADDR;
                    end
                end else if (count_q != '0) begin
                    // Drain only when the request port is quiet this cycle.
                    mp_address_d = buf_addr_q[head_q];
                    mp_data_d    = buf_data_q[head_q];
                    mp_wren_d    = 1'b1;
                    head_d       = head_q + 1'b1;
                    count_d      = count_q - 1'b1;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                resp_valid_d = 1'b1;
                resp_data_d  = mp_out;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mp_address_q <= '0;
            mp_data_q    <= '0;
            mp_wren_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mp_address_q <= mp_address_d;
            mp_data_q    <= mp_data_d;
            mp_wren_q    <= mp_wren_d;
        end
    end

    // Buffer storage needs no reset: slots are only read while counted as occupied.
    always_ff @(posedge clock) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mp_address = mp_address_q;
    assign mp_data    = mp_data_q;
    assign mp_wren    = mp_wren_q;
    assign wb_count   = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_m_wb_controller.sv
// Bench for m_wb_controller: RAM model, transaction-level reference model with
// per-cycle comparison, directed scenarios with literal expectations, random traffic.
module tb_m_wb_controller;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wren = 1'b0;
    logic [7:0] req_address = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic [7:0] mp_address;
    logic [7:0] mp_data;
    logic       mp_wren;
    logic [7:0] mp_out = 8'h00;
    logic [2:0] wb_count;
    logic       busy;

    m_wb_controller #(.DEPTH(DEPTH), .AW(8), .DW(8)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_wren(req_wren),
        .req_address(req_address), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .mp_address(mp_address),
        .mp_data(mp_data), .mp_wren(mp_wren), .mp_out(mp_out), .wb_count(wb_count),
        .busy(busy)
    );

    initial forever #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: RAM contents, logical memory view, pending write-back queue.
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] q_a[$];
    logic [7:0] q_d[$];
    int         rd_phase = 0;
    logic [7:0] rd_val = 8'h00;
    logic       e_resp_valid = 1'b0;
    logic [7:0] e_resp_data = 8'h00;
    logic       e_wren = 1'b0;
    logic       e_addr_chk = 1'b0;
    logic [7:0] e_mp_addr = 8'h00;
    logic [7:0] e_mp_data = 8'h00;

    initial begin
        int  idx;
        logic rdy;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h05] = 8'h2A;
        mem[8'h30] = 8'h3C;
        mem[8'h40] = 8'h00;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                q_a.delete();
                q_d.delete();
                rd_phase     = 0;
                e_resp_valid = 1'b0;
                e_resp_data  = 8'h00;
                e_wren       = 1'b0;
                e_addr_chk   = 1'b0;
                for (int i = 0; i < 256; i++) shadow[i] = mem[i];
            end else begin
                mp_out <= mem[mp_address];
                if (mp_wren) mem[mp_address] = mp_data;
                rdy          = (rd_phase == 0) && (q_a.size() != DEPTH);
                e_resp_valid = 1'b0;
                e_wren       = 1'b0;
                e_addr_chk   = 1'b0;
                idx          = -1;
                for (int i = 0; i < q_a.size(); i++) if (q_a[i] == req_address) idx = i;
                if (rd_phase == 1) begin
                    rd_phase = 2;
                end else if (rd_phase == 2) begin
                    rd_phase     = 0;
                    e_resp_valid = 1'b1;
                    e_resp_data  = rd_val;
                end else if (req_valid && rdy) begin
                    if (req_wren) begin
                        shadow[req_address] = req_data;
                        if (idx >= 0) q_d[idx] = req_data;
                        else begin
                            q_a.push_back(req_address);
                            q_d.push_back(req_data);
                        end
                    end else if (idx >= 0) begin
                        e_resp_valid = 1'b1;
                        e_resp_data  = shadow[req_address];
                    end else begin
                        rd_phase   = 1;
                        rd_val     = shadow[req_address];
                        e_mp_addr  = req_address;
                        e_addr_chk = 1'b1;
                    end
                end else if (q_a.size() > 0) begin
                    e_wren     = 1'b1;
                    e_addr_chk = 1'b1;
                    e_mp_addr  = q_a.pop_front();
                    e_mp_data  = q_d.pop_front();
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            chk("m_ready", 32'(req_ready), 32'((rd_phase == 0) && (q_a.size() != DEPTH)));
            chk("m_wb_count", 32'(wb_count), 32'(q_a.size()));
            chk("m_busy", 32'(busy), 32'((rd_phase != 0) || (q_a.size() != 0)));
            chk("m_resp_valid", 32'(resp_valid), 32'(e_resp_valid));
            chk("m_resp_data", 32'(resp_data), 32'(e_resp_data));
            chk("m_mp_wren", 32'(mp_wren), 32'(e_wren));
            if (e_addr_chk) chk("m_mp_address", 32'(mp_address), 32'(e_mp_addr));
            if (e_wren) chk("m_mp_data", 32'(mp_data), 32'(e_mp_data));
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, output int waits);
        logic r;
        logic done;
        req_valid = 1'b1; req_wren = w; req_address = a; req_data = d;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clock);
            r = req_ready;
            @(posedge clock);
            #1;
            if (r) done = 1'b1;
            else begin
                waits++;
                if (waits > 50) begin
                    chk("accept_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", 32'(n < 100), 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int cnt;
        logic [3:0] pat;
        logic seen;
        logic [7:0] ca, cd;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mp_wren", 32'(mp_wren), 32'd0);
        chk("rst_wb_count", 32'(wb_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: miss read of preloaded RAM word
        send(1'b0, 8'h05, 8'h00, w);
        chk("t1_ready_at_accept", 32'(w), 32'd0);
        pat = 4'h0; seen = 1'b0; cd = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            pat[k] = resp_valid;
            seen   = seen | mp_wren;
            if (resp_valid) cd = resp_data;
        end
        chk("t1_resp_timing", 32'(pat), 32'h4);
        chk("t1_resp_data", 32'(cd), 32'h2A);
        chk("t1_no_write", 32'(seen), 32'd0);
        @(posedge clock); #1;

        // 2: read forwarded from the buffer
        send(1'b1, 8'h03, 8'h11, w);
        send(1'b0, 8'h03, 8'h00, w);
        @(negedge clock);
        chk("t2_resp_valid", 32'(resp_valid), 32'd1);
        chk("t2_resp_data", 32'(resp_data), 32'h11);
        chk("t2_no_ram_read", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        wait_drain();

        // 3: coalesced writes to one address
        send(1'b1, 8'h07, 8'h01, w);
        send(1'b1, 8'h07, 8'h02, w);
        @(negedge clock);
        chk("t3_wb_count", 32'(wb_count), 32'd1);
        cnt = 0; ca = 8'h00; cd = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (mp_wren) begin cnt++; ca = mp_address; cd = mp_data; end
        end
        chk("t3_pulses", 32'(cnt), 32'd1);
        chk("t3_addr", 32'(ca), 32'h07);
        chk("t3_data", 32'(cd), 32'h02);
        chk("t3_ram", 32'(mem[8'h07]), 32'h02);
        @(posedge clock); #1;

        // 4: fill the buffer, then drain in order
        for (int i = 0; i < 4; i++) send(1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i), w);
        @(negedge clock);
        chk("t4_full_count", 32'(wb_count), 32'd4);
        chk("t4_full_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t4_pop_wren", 32'(mp_wren), 32'd1);
            chk("t4_pop_addr", 32'(mp_address), 32'h10 + 32'(i));
            chk("t4_pop_data", 32'(mp_data), 32'hA0 + 32'(i));
            if (i == 0) chk("t4_ready_after_pop", 32'(req_ready), 32'd1);
        end
        @(posedge clock); #1;
        wait_drain();

        // 5: write drained to RAM, then read it back through RAM
        send(1'b1, 8'h20, 8'h55, w);
        wait_drain();
        send(1'b0, 8'h20, 8'h00, w);
        cnt = 0;
        @(negedge clock);
        cnt = 1;
        chk("t5_ram_path", 32'(req_ready), 32'd0);
        while (!resp_valid && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
        chk("t5_latency", 32'(cnt), 32'd3);
        chk("t5_resp_data", 32'(resp_data), 32'h55);
        @(posedge clock); #1;

        // 6: reset during an in-flight read with a buffered write
        send(1'b1, 8'h40, 8'h77, w);
        send(1'b0, 8'h30, 8'h00, w);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_resp_data", 32'(resp_data), 32'd0);
        chk("t6_mp_address", 32'(mp_address), 32'd0);
        chk("t6_mp_wren", 32'(mp_wren), 32'd0);
        chk("t6_wb_count", 32'(wb_count), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            seen = seen | resp_valid;
        end
        chk("t6_no_pulse", 32'(seen), 32'd0);
        chk("t6_idle_ready", 32'(req_ready), 32'd1);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_write_dropped", 32'(mem[8'h40]), 32'h00);
        @(posedge clock); #1;

        // Random traffic over a narrow address window to exercise hits and coalescing.
        for (int c = 0; c < 3000; c++) begin
            req_valid   = ($urandom_range(0, 9) < 6);
            req_wren    = 1'($urandom_range(0, 1));
            req_address = 8'h50 + 8'($urandom_range(0, 7));
            req_data    = 8'($urandom);
            if (c == 1500) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/m_wb_controller.md
Name: m_wb_controller

Overview:
Main-memory-side controller that sits between the cache (m_cache) and the synchronous main-memory RAM (m_principal).
- Accepts cache fill reads and write-back writes over a valid/ready request port.
- Buffers write-backs in a small coalescing FIFO and drains them to RAM in idle cycles.
- Forwards buffered data to reads that hit the buffer, so the cache never sees stale RAM contents.

Parameters:
DEPTH, 4, write-back buffer entries (power of two, >=2)
AW, 8, address width
DW, 8, data width

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  cache request present
req_wren  in  1  1 = write-back, 0 = fill read
req_address  in  AW  request address
req_data  in  DW  write-back data (ignored on read)
req_ready  out  1  request accepted on edge where req_valid && req_ready
resp_valid  out  1  one-cycle pulse, read data valid
resp_data  out  DW  read data, held until next response
mp_address  out  AW  RAM address (registered)
mp_data  out  DW  RAM write data (registered)
mp_wren  out  1  RAM write enable (registered, one-cycle pulse per write)
mp_out  in  DW  RAM read data, valid the cycle after RAM samples mp_address
wb_count  out  $clog2(DEPTH+1)  occupied buffer entries
busy  out  1  state != IDLE or wb_count != 0

Behaviour:
- Clock and reset: one clock (clock); reset_n is asynchronous, active-low.
- Reset (async, reset_n=0):
  - state=IDLE; FIFO pointers and wb_count=0.
  - resp_valid=0, resp_data=0, mp_address=0, mp_data=0, mp_wren=0.
  - Buffered writes and in-flight reads are discarded.
- States: IDLE, RD_ADDR, RD_DATA.
- req_ready = (state==IDLE) && (wb_count != DEPTH). Combinational, independent of req_valid.
- Write accepted at edge E0:
  - If an entry with equal address exists, overwrite its data in place; wb_count unchanged.
  - Otherwise push {address,data} at the tail; wb_count+1.
  - The new data is visible to forwarding from the next cycle.
- Read accepted at E0, buffer hit (address match):
  - resp_data <= entry data, resp_valid=1 in the cycle after E0.
  - No RAM access; state stays IDLE.
- Read accepted at E0, buffer miss:
  - E0: mp_address <= req_address, mp_wren <= 0, state -> RD_ADDR.
  - E1: RAM samples the address; state -> RD_DATA.
  - E2: resp_data <= mp_out, resp_valid <= 1, state -> IDLE. resp_valid is high in the cycle after E2.
  - Only one read outstanding; req_ready=0 in RD_ADDR and RD_DATA.
- Drain:
  - At an IDLE edge where no request is accepted and wb_count>0:
    - mp_address <= head address, mp_data <= head data, mp_wren <= 1.
    - Pop head; wb_count-1.
  - Strict FIFO order, at most one write per cycle.
  - mp_wren returns to 0 the following edge unless another pop occurs.
- Priority: an accepted request (read or write) stalls the drain that cycle. When wb_count==DEPTH, req_ready=0, which forces draining.
- Coherence: a read issued after a pop registers its address one edge after the write reaches RAM, so it returns the written value.
- Pointers wrap modulo DEPTH; full and empty are determined by wb_count only.
- resp_valid is deasserted on every edge that does not produce a response.

Test Plan:
1. RAM[0x05]=0x2A; read 0x05 -> req_ready=1 at accept; resp_valid pulses exactly 1 cycle, 3 edges after accept (cycle after E2); resp_data=0x2A; mp_wren stays 0.
2. Write 0x03<-0x11, next cycle read 0x03 -> resp_valid the cycle after the read accept, resp_data=0x11; no RAM read issued.
3. Write 0x07<-0x01 then 0x07<-0x02 back-to-back -> wb_count=1; single drain with mp_address=0x07, mp_data=0x02; RAM[0x07]=0x02.
4. Four back-to-back writes 0x10..0x13 (data 0xA0..0xA3), req_valid held -> wb_count=4, req_ready=0; pops in order 0x10..0x13, one per cycle; req_ready=1 the cycle after the first pop.
5. Write 0x20<-0x55, wait until wb_count=0, then read 0x20 -> RAM path taken, resp_data=0x55.
6. Issue miss read 0x30, assert reset_n=0 during RD_DATA -> outputs zero immediately, no resp_valid pulse, wb_count=0, state IDLE after release.
